// File: rtl/sa_ram_fifo_ctrl_32x128_pkg.sv
// sa_ram_fifo_ctrl_32x128_pkg: shared sizing constants for the RAM-backed FIFO controller
package sa_ram_fifo_ctrl_32x128_pkg;
  localparam int SA_DEPTH = 32;
  localparam int SA_WIDTH = 128;
  localparam int SA_AW = 5;
  localparam int SA_CW = 6;
endpackage

// File: rtl/sa_ram_fifo_ctrl_32x128.sv
// sa_ram_fifo_ctrl_32x128: valid/ready FIFO controller driving an external 1-cycle-latency RAM
// wr_pvld/wr_prdy/wr_pd: push side; rd_pvld/rd_prdy/rd_pd: pop side (rd_pd is ram_dout)
// ram_we/ram_wa/ram_di: RAM write port; ram_re/ram_ra/ram_dout: registered RAM read port
// count: occupied entries, freed only on pop
module sa_ram_fifo_ctrl_32x128
  import sa_ram_fifo_ctrl_32x128_pkg::*;
#(
  parameter int DEPTH = SA_DEPTH,
  parameter int WIDTH = SA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic [SA_AW-1:0] ram_wa,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_di,
  output logic [SA_AW-1:0] ram_ra,
  output logic             ram_re,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [SA_CW-1:0] count
);
  logic [SA_AW-1:0] wr_ptr, rd_ptr;
  logic [SA_CW-1:0] unread;
  logic push, pop;
  assign wr_prdy = !rst && count != SA_CW'(DEPTH);
  assign push = wr_pvld && wr_prdy;
  assign pop = rd_pvld && rd_prdy;
  // unread only counts entries whose push edge has passed, so a read never races a same-cycle write
  assign ram_re = !rst && unread != '0 && (!rd_pvld || rd_prdy);
  assign ram_we = push;
  assign ram_wa = wr_ptr;
  assign ram_di = wr_pd;
  assign ram_ra = rd_ptr;
  assign rd_pd = ram_dout;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      unread <= '0;
      count <= '0;
      rd_pvld <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + SA_AW'(push);
      rd_ptr <= rd_ptr + SA_AW'(ram_re);
      unread <= unread + SA_CW'(push) - SA_CW'(ram_re);
      count <= count + SA_CW'(push) - SA_CW'(pop);
      rd_pvld <= ram_re || (rd_pvld && !rd_prdy);
    end
endmodule

// File: tb/tb_sa_ram_fifo_ctrl_32x128.sv
// tb_sa_ram_fifo_ctrl_32x128: directed self-checking bench with a 1-cycle-latency RAM beside the controller
module tb_sa_ram_fifo_ctrl_32x128;
  logic clk = 1'b0;
  logic rst, wr_pvld, wr_prdy, rd_pvld, rd_prdy, ram_we, ram_re;
  logic [127:0] wr_pd, rd_pd, ram_di, ram_dout;
  logic [4:0] ram_wa, ram_ra;
  logic [5:0] count;
  logic [127:0] mem [32];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ram_dout <= mem[ram_ra];
  end

  sa_ram_fifo_ctrl_32x128 dut (
    .clk(clk), .rst(rst), .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
    .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
    .ram_ra(ram_ra), .ram_re(ram_re), .ram_dout(ram_dout), .count(count)
  );

  function automatic logic [127:0] pat(int i, logic [7:0] tag);
    return {tag, 88'h0, 32'(i)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_pvld = 1'b0;
    rd_prdy = 1'b0;
    wr_pd = '0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_pvld = 1'b1;
    rd_prdy = 1'b1;
    wr_pd = '1;
    cyc();
    cyc();
    tests++; if (count !== 6'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
    tests++; if (rd_pvld !== 1'b0) begin fails++; $display("FAIL reset_rd_pvld: got %b want 0", rd_pvld); end
    tests++; if (wr_prdy !== 1'b0) begin fails++; $display("FAIL reset_wr_prdy: got %b want 0", wr_prdy); end
    tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    tests++; if (ram_re !== 1'b0) begin fails++; $display("FAIL reset_ram_re: got %b want 0", ram_re); end
    do_reset();
  endtask

  task automatic test_first_word();
    logic [127:0] a5 = {16{8'hA5}};
    do_reset();
    wr_pvld = 1'b1;
    wr_pd = a5;
    #1;
    tests++; if (ram_we !== 1'b1 || ram_wa !== 5'd0) begin fails++; $display("FAIL fw_write: got we=%b wa=%0d want we=1 wa=0", ram_we, ram_wa); end
    tests++; if (ram_di !== a5) begin fails++; $display("FAIL fw_ram_di: got %h want %h", ram_di, a5); end
    tests++; if (ram_re !== 1'b0) begin fails++; $display("FAIL fw_no_early_re: got %b want 0", ram_re); end
    cyc();
    wr_pvld = 1'b0;
    #1;
    tests++; if (ram_re !== 1'b1 || ram_ra !== 5'd0) begin fails++; $display("FAIL fw_re: got re=%b ra=%0d want re=1 ra=0", ram_re, ram_ra); end
    tests++; if (count !== 6'd1 || rd_pvld !== 1'b0) begin fails++; $display("FAIL fw_c2: got count=%0d pvld=%b want 1 0", count, rd_pvld); end
    cyc();
    tests++; if (rd_pvld !== 1'b1 || rd_pd !== a5) begin fails++; $display("FAIL fw_rd: got pvld=%b pd=%h want 1 %h", rd_pvld, rd_pd, a5); end
    tests++; if (ram_re !== 1'b0) begin fails++; $display("FAIL fw_re_once: got %b want 0", ram_re); end
    cyc();
    tests++; if (count !== 6'd1 || rd_pvld !== 1'b1 || rd_pd !== a5) begin fails++; $display("FAIL fw_hold: got count=%0d pvld=%b pd=%h", count, rd_pvld, rd_pd); end
    rd_prdy = 1'b1;
    cyc();
    rd_prdy = 1'b0;
    tests++; if (count !== 6'd0 || rd_pvld !== 1'b0) begin fails++; $display("FAIL fw_pop: got count=%0d pvld=%b want 0 0", count, rd_pvld); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      wr_pvld = 1'b1;
      wr_pd = pat(i, 8'h1F);
      #1;
      tests++; if (wr_prdy !== 1'b1) begin fails++; $display("FAIL fill_prdy_%0d: got %b want 1", i, wr_prdy); end
      cyc();
    end
    wr_pd = pat(99, 8'hEE);
    #1;
    tests++; if (count !== 6'd32) begin fails++; $display("FAIL fill_count: got %0d want 32", count); end
    tests++; if (wr_prdy !== 1'b0 || ram_we !== 1'b0) begin fails++; $display("FAIL fill_refuse: got prdy=%b we=%b want 0 0", wr_prdy, ram_we); end
    cyc();
    wr_pvld = 1'b0;
    tests++; if (count !== 6'd32) begin fails++; $display("FAIL fill_count_after33: got %0d want 32", count); end
    tests++; if (rd_pvld !== 1'b1 || rd_pd !== pat(0, 8'h1F)) begin fails++; $display("FAIL fill_head: got pvld=%b pd=%h want 1 %h", rd_pvld, rd_pd, pat(0, 8'h1F)); end
  endtask

  task automatic test_full_pop();
    logic [127:0] q[$];
    bit done = 0;
    rd_prdy = 1'b1;
    wr_pvld = 1'b1;
    wr_pd = pat(32, 8'h1F);
    #1;
    tests++; if (wr_prdy !== 1'b0 || ram_we !== 1'b0) begin fails++; $display("FAIL fp_refuse: got prdy=%b we=%b want 0 0", wr_prdy, ram_we); end
    tests++; if (ram_re !== 1'b1) begin fails++; $display("FAIL fp_re: got %b want 1", ram_re); end
    cyc();
    rd_prdy = 1'b0;
    tests++; if (count !== 6'd31) begin fails++; $display("FAIL fp_count31: got %0d want 31", count); end
    #1;
    tests++; if (wr_prdy !== 1'b1 || ram_we !== 1'b1) begin fails++; $display("FAIL fp_accept: got prdy=%b we=%b want 1 1", wr_prdy, ram_we); end
    cyc();
    wr_pvld = 1'b0;
    tests++; if (count !== 6'd32) begin fails++; $display("FAIL fp_count32: got %0d want 32", count); end
    for (int i = 1; i <= 32; i++) q.push_back(pat(i, 8'h1F));
    rd_prdy = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      if (rd_pvld) begin
        tests++; if (rd_pd !== q[0]) begin fails++; $display("FAIL fp_drain: got %h want %h", rd_pd, q[0]); end
        void'(q.pop_front());
      end
      done = q.size() == 0;
      if (!done) cyc();
    end
    tests++; if (!done) begin fails++; $display("FAIL fp_drain_timeout: got %0d left want 0", q.size()); end
    cyc();
    rd_prdy = 1'b0;
    tests++; if (count !== 6'd0 || rd_pvld !== 1'b0) begin fails++; $display("FAIL fp_empty: got count=%0d pvld=%b want 0 0", count, rd_pvld); end
  endtask

  task automatic test_stream();
    int tx = 0, rx = 0, wraps = 0, first = -1, last = -1;
    do_reset();
    rd_prdy = 1'b1;
    for (int c = 0; c < 300 && rx < 100; c++) begin
      if (rd_pvld) begin
        tests++; if (rd_pd !== pat(rx, 8'h77)) begin fails++; $display("FAIL stream_data_%0d: got %h want %h", rx, rd_pd, pat(rx, 8'h77)); end
        if (first < 0) first = c;
        last = c;
        rx++;
      end
      wr_pvld = tx < 100;
      wr_pd = pat(tx, 8'h77);
      #1;
      if (ram_we && ram_wa == 5'd31) wraps++;
      if (wr_pvld && wr_prdy) tx++;
      cyc();
    end
    wr_pvld = 1'b0;
    tests++; if (rx !== 100) begin fails++; $display("FAIL stream_count: got %0d want 100", rx); end
    tests++; if (last - first !== 99) begin fails++; $display("FAIL stream_rate: got %0d cycles want 99", last - first); end
    tests++; if (wraps !== 3) begin fails++; $display("FAIL stream_wraps: got %0d want 3", wraps); end
    cyc();
    tests++; if (count !== 6'd0) begin fails++; $display("FAIL stream_empty: got %0d want 0", count); end
    rd_prdy = 1'b0;
  endtask

  task automatic test_stall();
    int tx = 0, rx = 0;
    bit prev_stall = 0;
    logic [127:0] prev_pd;
    do_reset();
    for (int c = 0; c < 600 && rx < 40; c++) begin
      if (prev_stall) begin
        tests++; if (rd_pvld !== 1'b1 || rd_pd !== prev_pd) begin fails++; $display("FAIL stall_hold: got pvld=%b pd=%h want 1 %h", rd_pvld, rd_pd, prev_pd); end
      end
      rd_prdy = 1'($urandom_range(0, 1));
      if (rd_pvld && rd_prdy) begin
        tests++; if (rd_pd !== pat(rx, 8'h5A)) begin fails++; $display("FAIL stall_data_%0d: got %h want %h", rx, rd_pd, pat(rx, 8'h5A)); end
        rx++;
      end
      prev_stall = rd_pvld && !rd_prdy;
      prev_pd = rd_pd;
      wr_pvld = tx < 40;
      wr_pd = pat(tx, 8'h5A);
      #1;
      if (wr_pvld && wr_prdy) tx++;
      cyc();
    end
    wr_pvld = 1'b0;
    rd_prdy = 1'b0;
    tests++; if (rx !== 40) begin fails++; $display("FAIL stall_count: got %0d want 40", rx); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      wr_pvld = 1'b1;
      wr_pd = pat(i, 8'hCC);
      cyc();
    end
    wr_pvld = 1'b0;
    cyc();
    tests++; if (count !== 6'd10 || rd_pvld !== 1'b1) begin fails++; $display("FAIL rm_held: got count=%0d pvld=%b want 10 1", count, rd_pvld); end
    rst = 1'b1;
    wr_pvld = 1'b1;
    rd_prdy = 1'b1;
    #1;
    tests++; if (wr_prdy !== 1'b0 || ram_we !== 1'b0 || ram_re !== 1'b0) begin fails++; $display("FAIL rm_gate: got prdy=%b we=%b re=%b want 0 0 0", wr_prdy, ram_we, ram_re); end
    cyc();
    rst = 1'b0;
    wr_pvld = 1'b0;
    rd_prdy = 1'b0;
    tests++; if (count !== 6'd0 || rd_pvld !== 1'b0) begin fails++; $display("FAIL rm_cleared: got count=%0d pvld=%b want 0 0", count, rd_pvld); end
    wr_pvld = 1'b1;
    wr_pd = pat(7, 8'hB0);
    #1;
    tests++; if (ram_we !== 1'b1 || ram_wa !== 5'd0 || ram_re !== 1'b0) begin fails++; $display("FAIL rm_push: got we=%b wa=%0d re=%b want 1 0 0", ram_we, ram_wa, ram_re); end
    cyc();
    wr_pvld = 1'b0;
    #1;
    tests++; if (ram_re !== 1'b1 || ram_ra !== 5'd0) begin fails++; $display("FAIL rm_re: got re=%b ra=%0d want 1 0", ram_re, ram_ra); end
    cyc();
    tests++; if (rd_pvld !== 1'b1 || rd_pd !== pat(7, 8'hB0) || count !== 6'd1) begin fails++; $display("FAIL rm_rd: got pvld=%b pd=%h count=%0d", rd_pvld, rd_pd, count); end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_fill();
    test_full_pop();
    test_stream();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
